// File: rtl/bf_sweep_if.sv
// Handshake and edge-address bundle between the run controller, the relaxation
// pipeline and the Bellman-Ford iteration sequencer.
interface bf_sweep_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned IW = 6
) ();
    logic          start;
    logic          up;
    logic [AW-1:0] addr;
    logic          edge_vld;
    logic [IW-1:0] iter;
    logic          busy;
    logic          done;
    logic          converged;
    logic          neg_cycle;

    // Host / pipeline side.
    modport master (
        output start, up,
        input  addr, edge_vld, iter, busy, done, converged, neg_cycle
    );

    // Sequencer side.
    modport slave (
        input  start, up,
        output addr, edge_vld, iter, busy, done, converged, neg_cycle
    );
endinterface

// File: rtl/bf_sweep_ctrl.sv
// Bellman-Ford iteration sequencer: sweeps edge addresses, drains the relaxation
// pipeline, and ends the run on convergence or on a detected negative cycle.
module bf_sweep_ctrl #(
    parameter int unsigned AW        = 5,
    parameter int unsigned NUM_EDGES = 32,
    parameter int unsigned NUM_NODES = 16,
    parameter int unsigned PIPE_LAT  = 3,
    parameter int unsigned IW        = 6
) (
    input logic        clk,
    input logic        clr,
    bf_sweep_if.slave  bus
);
    localparam int unsigned CW = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSweep = 3'd1;
    localparam logic [2:0] StDrain = 3'd2;
    localparam logic [2:0] StCheck = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [AW-1:0] LastAddr = AW'(NUM_EDGES - 1);
    localparam logic [IW-1:0] LastIter = IW'(NUM_NODES);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          vld_q, vld_d;
    logic [IW-1:0] iter_q, iter_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          conv_q, conv_d;
    logic          neg_q, neg_d;
    logic          upd_q, upd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        vld_d   = vld_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        done_d  = done_q;
        conv_d  = conv_q;
        neg_d   = neg_q;
        upd_d   = upd_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StSweep;
                    addr_d  = '0;
                    vld_d   = 1'b1;
                    iter_d  = IW'(1);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    conv_d  = 1'b0;
                    neg_d   = 1'b0;
                    upd_d   = 1'b0;
                end
            end
            StSweep: begin
                upd_d = upd_q | bus.up;
                if (addr_q == LastAddr) begin
                    state_d = StDrain;
                    vld_d   = 1'b0;
                    cnt_d   = CW'(PIPE_LAT);
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            StDrain: begin
                // An update landing on the last drain cycle still belongs to this sweep.
                upd_d = upd_q | bus.up;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (!upd_q) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    conv_d  = 1'b1;
                end else if (iter_q == LastIter) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    neg_d   = 1'b1;
                end else begin
                    state_d = StSweep;
                    iter_d  = iter_q + IW'(1);
                    upd_d   = 1'b0;
                    addr_d  = '0;
                    vld_d   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            neg_q   <= 1'b0;
            upd_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            iter_q  <= iter_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            conv_q  <= conv_d;
            neg_q   <= neg_d;
            upd_q   <= upd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.addr      = addr_q;
    assign bus.edge_vld  = vld_q;
    assign bus.iter      = iter_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.converged = conv_q;
    assign bus.neg_cycle = neg_q;
endmodule

// File: tb/tb_bf_sweep_ctrl.sv
// Directed bench for bf_sweep_ctrl: a timeline model of each run checked every cycle,
// plus literal expectations on run length and final status.
module tb_bf_sweep_ctrl;
    localparam int AW = 5;
    localparam int IW = 6;
    localparam int NE = 32;
    localparam int NN = 16;
    localparam int PL = 3;
    localparam int P  = NE + PL + 1;

    logic clk;
    logic clr;

    bf_sweep_if #(.AW(AW), .IW(IW)) bus ();

    bf_sweep_ctrl #(
        .AW        (AW),
        .NUM_EDGES (NE),
        .NUM_NODES (NN),
        .PIPE_LAT  (PL),
        .IW        (IW)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int j        = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Timeline model: a run is a sequence of P-cycle iterations counted from the start edge.
    bit m_valid = 0;
    bit m_run   = 0;
    bit m_upd   = 0;
    bit m_done  = 0;
    bit m_conv  = 0;
    bit m_neg   = 0;
    int m_k     = 0;
    int m_iter_fin  = 0;
    int m_addr_rest = 0;
    int m_o;

    always @(posedge clk) begin
        if (clr) begin
            m_valid = 1; m_run = 0; m_upd = 0;
            m_done = 0; m_conv = 0; m_neg = 0;
            m_iter_fin = 0; m_addr_rest = 0;
        end else if (m_run) begin
            m_o = m_k % P;
            if (m_o < NE + PL && bus.up) m_upd = 1;
            if (m_o == P - 1) begin
                if (!m_upd || (m_k / P + 1 == NN)) begin
                    m_run = 0; m_done = 1;
                    m_conv = !m_upd; m_neg = m_upd;
                    m_iter_fin = m_k / P + 1;
                    m_addr_rest = NE - 1;
                end else begin
                    m_upd = 0;
                end
            end
            m_k++;
        end else if (bus.start && m_valid) begin
            m_run = 1; m_k = 0; m_upd = 0;
            m_done = 0; m_conv = 0; m_neg = 0;
        end
    end

    int e_o;
    always @(negedge clk) begin
        if (m_valid) begin
            e_o = m_k % P;
            chk("addr",      int'(bus.addr),
                m_run ? ((e_o < NE) ? e_o : NE - 1) : m_addr_rest);
            chk("edge_vld",  int'(bus.edge_vld), int'(m_run && e_o < NE));
            chk("iter",      int'(bus.iter), m_run ? (m_k / P + 1) : m_iter_fin);
            chk("busy",      int'(bus.busy), int'(m_run));
            chk("done",      int'(bus.done), int'(m_done));
            chk("converged", int'(bus.converged), int'(m_conv));
            chk("neg_cycle", int'(bus.neg_cycle), int'(m_neg));
        end
    end

    task automatic tick();
        @(negedge clk);
        j++;
    endtask

    // Raises start for one edge; returns at the first cycle after the start edge (j=1).
    task automatic start_run();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        j = 1;
    endtask

    int nv;

    initial begin
        clr = 1'b1;
        bus.start = 1'b0;
        bus.up = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        tick();
        chk("rst_addr", int'(bus.addr), 0);
        chk("rst_iter", int'(bus.iter), 0);
        chk("rst_done", int'(bus.done), 0);

        // No updates: one sweep then converge.
        start_run();
        chk("t1_first_vld", int'(bus.edge_vld), 1);
        chk("t1_first_busy", int'(bus.busy), 1);
        nv = 0;
        while (!bus.done && j < 200) begin
            if (bus.edge_vld) nv++;
            tick();
        end
        chk("t1_done_cycle", j, 37);
        chk("t1_vld_cycles", nv, 32);
        chk("t1_conv", int'(bus.converged), 1);
        chk("t1_iter", int'(bus.iter), 1);

        // Updates at addr 7 of sweep 1 and on the last drain cycle of sweep 2.
        start_run();
        while (!bus.done && j < 400) begin
            bus.up = (j == 8 || j == 71);
            tick();
        end
        bus.up = 1'b0;
        chk("t2_done_cycle", j, 3 * P + 1);
        chk("t2_conv", int'(bus.converged), 1);
        chk("t2_neg", int'(bus.neg_cycle), 0);
        chk("t2_iter", int'(bus.iter), 3);

        // Persistent updates: negative cycle after NN sweeps.
        start_run();
        bus.up = 1'b1;
        while (!bus.done && j < 700) tick();
        bus.up = 1'b0;
        chk("t3_done_cycle", j, NN * P + 1);
        chk("t3_neg", int'(bus.neg_cycle), 1);
        chk("t3_conv", int'(bus.converged), 0);
        chk("t3_iter", int'(bus.iter), NN);

        // Restart from DONE clears status; start pulses in SWEEP and DRAIN are ignored.
        start_run();
        chk("t6_done_clr", int'(bus.done), 0);
        chk("t6_neg_clr", int'(bus.neg_cycle), 0);
        chk("t6_addr", int'(bus.addr), 0);
        chk("t6_iter", int'(bus.iter), 1);
        while (!bus.done && j < 200) begin
            bus.start = (j == 10 || j == 34);
            tick();
        end
        bus.start = 1'b0;
        chk("t6_done_cycle", j, 37);
        start_run();
        chk("t6b_done_clr", int'(bus.done), 0);
        chk("t6b_conv_clr", int'(bus.converged), 0);
        chk("t6b_iter", int'(bus.iter), 1);
        while (!bus.done && j < 200) tick();
        chk("t6b_done_cycle", j, 37);

        // up in IDLE, in CHECK and in DONE is ignored.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bus.up = 1'b1;
        repeat (3) tick();
        bus.up = 1'b0;
        start_run();
        while (!bus.done && j < 200) begin
            bus.up = (j == 36);
            tick();
        end
        bus.up = 1'b1;
        repeat (2) tick();
        bus.up = 1'b0;
        chk("t4_conv", int'(bus.converged), 1);
        chk("t4_iter", int'(bus.iter), 1);

        // clr at addr 10 of sweep 2 abandons the run.
        start_run();
        while (j < 47) begin
            bus.up = (j == 5);
            tick();
        end
        bus.up = 1'b0;
        chk("t5_pre_iter", int'(bus.iter), 2);
        chk("t5_pre_addr", int'(bus.addr), 10);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_addr", int'(bus.addr), 0);
        chk("t5_iter", int'(bus.iter), 0);
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_done", int'(bus.done), 0);
        repeat (5) tick();
        chk("t5_no_done", int'(bus.done), 0);
        start_run();
        while (!bus.done && j < 200) tick();
        chk("t5_rerun_cycle", j, 37);
        chk("t5_rerun_iter", int'(bus.iter), 1);
        chk("t5_rerun_conv", int'(bus.converged), 1);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bf_sweep_ctrl.md
# bf_sweep_ctrl

Iteration sequencer for the pipelined Bellman-Ford relaxation datapath. It drives the edge-memory address sweep, drains the relaxation pipeline after each sweep, and collects the per-edge update flags. It stops early when a sweep produces no distance update, or flags a negative cycle when updates persist past NUM_NODES sweeps. It sits between the top-level start/done handshake and the edge-address input of the relaxation pipeline.

## Interface
- AW, 5: edge address width
- NUM_EDGES, 32: edges per sweep, 1..2^AW
- NUM_NODES, 16: graph node count; sweeps NUM_NODES-1 relax, sweep NUM_NODES is the negative-cycle check
- PIPE_LAT, 3: cycles from an address issued to its `up` flag, ≥1
- IW, 6: iteration counter width, must hold NUM_NODES

- clk  in  1  system clock, all logic on rising edge
- clr  in  1  synchronous, active-high reset
- start  in  1  begin a run; honoured only in IDLE or DONE
- up  in  1  update flag from the pipeline: some edge relaxed this cycle
- addr  out  AW  edge address to the pipeline
- edge_vld  out  1  addr is a live edge this cycle
- iter  out  IW  current sweep number, 1-based
- busy  out  1  high in SWEEP, DRAIN and CHECK
- done  out  1  run finished; level, held until start or clr
- converged  out  1  run ended on an update-free sweep
- neg_cycle  out  1  updates still present in sweep NUM_NODES

## Operation
- States: IDLE, SWEEP, DRAIN, CHECK, DONE. All outputs are registered.
- **Reset** (clr high at an edge, any state): state=IDLE, addr=0, edge_vld=0, iter=0, busy=0, done=0, converged=0, neg_cycle=0, sticky update flag upd_seen=0, drain counter=0. clr has priority over every other input.
- **IDLE**: start → SWEEP. On entry: addr=0, iter=1, upd_seen=0, done/converged/neg_cycle cleared.
- **SWEEP**: edge_vld=1; addr increments by 1 each cycle.
  - When addr==NUM_EDGES-1, the next state is DRAIN, edge_vld drops, and the drain counter loads PIPE_LAT.
  - addr never wraps inside a sweep.
- **DRAIN**: edge_vld=0; addr holds NUM_EDGES-1. The counter decrements each cycle; at 1 → CHECK.
- **upd_seen**: set by `up` sampled in SWEEP or DRAIN. `up` is ignored in IDLE, CHECK and DONE.
- **CHECK** (exactly one cycle):
  - upd_seen=0 → DONE with converged=1.
  - Otherwise, iter==NUM_NODES → DONE with neg_cycle=1.
  - Otherwise iter increments, upd_seen clears, addr=0, next state SWEEP.
- **DONE**: busy=0, done=1, iter frozen at the final sweep number.
  - start → same entry as from IDLE; done/converged/neg_cycle drop on that edge.
- start while busy is ignored (no restart, no effect on the run).
- converged and neg_cycle are never both 1.

## Timing
- start sampled at edge 0 → SWEEP from edge 1, with addr=0, edge_vld=1, busy=1.
- One iteration takes NUM_EDGES + PIPE_LAT + 1 cycles. With the defaults this is 36.
- An update-free first sweep gives done=1 exactly 1+NUM_EDGES+PIPE_LAT+1 cycles after the start edge.
- The next sweep's addr=0 appears the cycle after CHECK. There is no bubble beyond the CHECK cycle.
- `up` arriving on the last DRAIN cycle counts toward the current sweep. `up` on the first cycle of the next SWEEP counts toward the new sweep.
- Worst-case run: NUM_NODES × (NUM_EDGES+PIPE_LAT+1) cycles after entry to SWEEP.
- clr mid-run: outputs hold reset values from the next cycle. The run is abandoned and no done is produced.

## Test plan
- **No updates**: defaults, start pulse, up=0 throughout → done=1 and converged=1 with iter=1, 37 cycles after the start edge; addr sweeps 0..31 with edge_vld high for exactly 32 cycles.
- **Convergence after three sweeps**: up pulsed at addr=7 in sweep 1 and on the final DRAIN cycle of sweep 2, none in sweep 3 → converged=1, iter=3, neg_cycle=0.
- **Negative cycle**: up held high every sweep → after 16 sweeps done=1, neg_cycle=1, converged=0, iter=16.
- **Update outside sweep/drain**: up asserted only during the CHECK cycle, and during IDLE before start → ignored; converged at iter=1.
- **Reset mid-run**: clr at addr=10 of sweep 2 → next cycle IDLE, addr=0, iter=0, busy=0, done=0. A later start runs cleanly from iter=1.
- **Start handling**: start while busy (SWEEP and DRAIN) → no effect. start in DONE → done, converged and neg_cycle clear on that edge; a new sweep begins with addr=0, iter=1.
